alu: RTL and testbench

- Parameterised N-bit integer ALU: AND, OR, ADD, SUB, SLT, plus AND/OR with inverted B.
- Flags: zero, carry-out and signed overflow.
- Datapath leaf block for the single-cycle/pipelined CPU execute stage.
- Inputs are sampled on the clock edge; results and flags are registered with one-cycle latency.

---
 rtl/alu.sv | 76 +++++++
 tb/tb_alu.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered N-bit integer ALU for the CPU execute stage: logic ops, add/sub, signed SLT,
// with zero / carry-out / signed-overflow flags, all one cycle after the operands are sampled.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             slt;

    logic [WIDTH-1:0] y_d, y_q;
    logic             zero_d, zero_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;

    // f[2] selects inverted B and supplies the +1, so one adder serves both ADD and SUB/SLT.
    always_comb begin
        bb  = f[2] ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, f[2]};
        c   = sum[WIDTH];
        s   = sum[WIDTH-1:0];
        v   = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        slt = s[WIDTH-1] ^ v;
    end

    always_comb begin
        y_d     = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        unique case (f[1:0])
            2'b00: y_d = a & bb;
            2'b01: y_d = a | bb;
            2'b10: begin
                y_d     = s;
                carry_d = c;
                ovf_d   = v;
            end
            2'b11: y_d = f[2] ? {{(WIDTH-1){1'b0}}, slt} : '0;
            default: y_d = '0;
        endcase
        zero_d = (y_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y         = y_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: each step drives operands, waits one edge and checks y and flags.
module tb_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       f;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             carry_out;
    logic             overflow;

    int tests;
    int fails;

    alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .f         (f),
        .y         (y),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] ey,
                         input logic ez, input logic ec, input logic ev);
        tests++;
        assert ({y, zero, carry_out, overflow} === {ey, ez, ec, ev})
        else begin
            fails++;
            $error("FAIL %s: got y=%h z=%b c=%b v=%b, expected y=%h z=%b c=%b v=%b",
                   tag, y, zero, carry_out, overflow, ey, ez, ec, ev);
        end
    endtask

    task automatic step(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic [2:0] tf);
        a = ta;
        b = tb_;
        f = tf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a = 32'h1234_5678;
        b = 32'h0000_0001;
        f = 3'b010;

        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 32'h0, 1'b1, 1'b0, 1'b0);

        rst_n = 1'b1;
        step(32'h1234_5678, 32'h0000_FFFF, 3'b000);
        check("post_reset_and", 32'h0000_5678, 1'b0, 1'b0, 1'b0);

        // ADD
        step(32'hFFFF_FFFF, 32'h0000_0001, 3'b010);
        check("add_wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        step(32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
        check("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

        // SUB
        step(32'h0000_0005, 32'h0000_0005, 3'b110);
        check("sub_equal", 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        step(32'h8000_0000, 32'h0000_0001, 3'b110);
        check("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        step(32'h0000_0000, 32'h0000_0001, 3'b110);
        check("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step(32'h0000_1234, 32'h0000_0000, 3'b110);
        check("sub_zero_b", 32'h0000_1234, 1'b0, 1'b1, 1'b0);

        // SLT
        step(32'hFFFF_FFFF, 32'h0000_0001, 3'b111);
        check("slt_neg_lt", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0001, 32'hFFFF_FFFF, 3'b111);
        check("slt_pos_ge", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        step(32'h8000_0000, 32'h0000_0001, 3'b111);
        check("slt_ovf", 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        // Logic ops
        step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
        check("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001);
        check("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100);
        check("and_nb", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
        step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101);
        check("or_nb", 32'hF0FF_F0FF, 1'b0, 1'b0, 1'b0);
        step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011);
        check("reserved", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 32'h0000_0001, 3'b011);
        check("reserved_noflags", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        // Back-to-back issue
        step(32'd1, 32'd2, 3'b010);
        check("pipe_add", 32'd3, 1'b0, 1'b0, 1'b0);
        step(32'd10, 32'd3, 3'b110);
        check("pipe_sub", 32'd7, 1'b0, 1'b1, 1'b0);
        step(32'd6, 32'd3, 3'b000);
        check("pipe_and", 32'd2, 1'b0, 1'b0, 1'b0);

        // Same sequence with reset on the third edge
        step(32'd1, 32'd2, 3'b010);
        check("pipe2_add", 32'd3, 1'b0, 1'b0, 1'b0);
        step(32'd10, 32'd3, 3'b110);
        check("pipe2_sub", 32'd7, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(32'd6, 32'd3, 3'b000);
        check("pipe2_reset", 32'd0, 1'b1, 1'b0, 1'b0);

        rst_n = 1'b1;
        step(32'd6, 32'd3, 3'b000);
        check("after_reset_and", 32'd2, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
